// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Q16.16 convolution path: data width, kernel size and
// the row-major window index map used by both the window feeder and the convolution.
package conv_pkg;

    localparam int CONV_DATA_W = 32;
    localparam int FRAC_BITS   = 16;
    localparam int KERNEL      = 3;
    localparam int WIN_N       = KERNEL * KERNEL;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    function automatic int win_idx(input int row, input int col);
        return row * KERNEL + col;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of storage: combinational read and synchronous write at the same
// address, so a read-then-overwrite happens in a single accept cycle.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Line storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// Raster-stream to 3x3 window feeder: two line buffers plus a 3x3 shift register,
// emitting only complete (unpadded) neighbourhoods with valid/ready on both sides.
module conv_window_3x3
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        win0,
    output logic [DATA_W-1:0]        win1,
    output logic [DATA_W-1:0]        win2,
    output logic [DATA_W-1:0]        win3,
    output logic [DATA_W-1:0]        win4,
    output logic [DATA_W-1:0]        win5,
    output logic [DATA_W-1:0]        win6,
    output logic [DATA_W-1:0]        win7,
    output logic [DATA_W-1:0]        win8,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic              out_valid_q, out_valid_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic [COL_W-1:0]  out_col_q, out_col_d;
    logic [DATA_W-1:0] win_q [WIN_N];
    logic [DATA_W-1:0] win_d [WIN_N];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic              accept;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign cur_row  = in_sof ? '0 : row_q;
    assign cur_col  = in_sof ? '0 : col_q;

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wr_data (in_data),
        .rd_data (lb0_rd)
    );

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Next-state: raster counters, window shift and output-valid handshake.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        for (int i = 0; i < WIN_N; i++) begin
            win_d[i] = win_q[i];
        end

        if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
                end
            end
            win_d[WIN_TR] = lb1_rd;
            win_d[WIN_MR] = lb0_rd;
            win_d[WIN_BR] = in_data;

            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end

            out_valid_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            out_row_d   = cur_row - ROW_W'(1);
            out_col_d   = cur_col - COL_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign win0      = win_q[WIN_TL];
    assign win1      = win_q[WIN_TC];
    assign win2      = win_q[WIN_TR];
    assign win3      = win_q[WIN_ML];
    assign win4      = win_q[WIN_MC];
    assign win5      = win_q[WIN_MR];
    assign win6      = win_q[WIN_BL];
    assign win7      = win_q[WIN_BC];
    assign win8      = win_q[WIN_BR];

endmodule

// File: tb/tb_conv_window_3x3.sv
// Bench for conv_window_3x3 on a 4x4 image: an image-array reference model predicts
// every window, and scenario tasks check latency, stalls, resets and frame resync.
module tb_conv_window_3x3;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int IH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic [8:0][DW-1:0] act_w;

    int n_checks = 0;
    int n_fail   = 0;
    int n_win    = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        logic [8:0][DW-1:0] w;
        logic [1:0]         row;
        logic [1:0]         col;
    } win_t;

    win_t          exp_q[$];
    win_t          e_m;
    logic [DW-1:0] img [IH][IW];
    int            mr = 0, mc = 0, r_m, c_m;
    int            first_idx [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    conv_window_3x3 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .out_row(out_row), .out_col(out_col)
    );

    assign act_w = {win8, win7, win6, win5, win4, win3, win2, win1, win0};

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input int p);
        return 32'(p) << 16;
    endfunction

    // Reference model and scoreboard: the image is stored as a 2-D array and each
    // window is cut out of it directly when its bottom-right pixel is accepted.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
            end
            n_checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++;
                $display("FAIL in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && exp_q.size() != 0) begin
                n_checks++;
                if (act_w !== exp_q[0].w || out_row !== exp_q[0].row || out_col !== exp_q[0].col) begin
                    n_fail++;
                    $display("FAIL window: got %h r%0d c%0d expected %h r%0d c%0d",
                             act_w, out_row, out_col, exp_q[0].w, exp_q[0].row, exp_q[0].col);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_win++;
                end
            end
            if (!rst_n) begin
                exp_q.delete();
                mr = 0;
                mc = 0;
            end else if (in_valid && in_ready) begin
                r_m = in_sof ? 0 : mr;
                c_m = in_sof ? 0 : mc;
                img[r_m][c_m] = in_data;
                if (r_m >= 2 && c_m >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e_m.w[i*3+j] = img[r_m-2+i][c_m-2+j];
                    e_m.row = 2'(r_m - 1);
                    e_m.col = 2'(c_m - 1);
                    exp_q.push_back(e_m);
                end
                mc = c_m + 1;
                if (mc == IW) begin
                    mc = 0;
                    mr = (r_m + 1) % IH;
                end else begin
                    mr = r_m;
                end
            end
        end
    end

    task automatic push_pixel(input logic [DW-1:0] d, input logic sof, input int gap);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || act_w !== '0 || out_row !== 2'd0 || out_col !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v%b w%h r%0d c%0d rdy%b expected all zero, ready 1",
                     out_valid, act_w, out_row, out_col, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int w0;
        do_reset();
        w0 = n_win;
        for (int p = 0; p < 16; p++) begin
            push_pixel(pix(p), p == 0, 0);
            if (p == 10) begin
                @(negedge clk);
                n_checks++;
                if (out_valid !== 1'b1 || out_row !== 2'd1 || out_col !== 2'd1) begin
                    n_fail++;
                    $display("FAIL first_window_pos: got v%b r%0d c%0d expected v1 r1 c1", out_valid, out_row, out_col);
                end
                for (int i = 0; i < 9; i++) begin
                    n_checks++;
                    if (act_w[i] !== pix(first_idx[i])) begin
                        n_fail++;
                        $display("FAIL first_window_win%0d: got %h expected %h", i, act_w[i], pix(first_idx[i]));
                    end
                end
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || win8 !== pix(15) || out_row !== 2'd2 || out_col !== 2'd2) begin
            n_fail++;
            $display("FAIL last_window: got v%b win8 %h r%0d c%0d expected v1 %h r2 c2",
                     out_valid, win8, out_row, out_col, pix(15));
        end
        @(posedge clk); #1;
        drain();
        n_checks++;
        if (n_win - w0 != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_frame_count: got %0d expected 4", n_win - w0);
        end
    endtask

    task automatic test_backpressure();
        int w0;
        logic [8:0][DW-1:0] snap;
        do_reset();
        w0 = n_win;
        for (int p = 0; p < 11; p++) push_pixel(pix(p), p == 0, 0);
        out_ready = 1'b0;
        @(negedge clk);
        snap = act_w;
        n_checks++;
        if (snap[8] !== pix(10)) begin
            n_fail++;
            $display("FAIL stall_first_win8: got %h expected %h", snap[8], pix(10));
        end
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || act_w !== snap || out_row !== 2'd1 || out_col !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_hold: got rdy%b v%b w%h r%0d c%0d expected rdy0 v1 w%h r1 c1",
                         in_ready, out_valid, act_w, out_row, out_col, snap);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_pixel(pix(11), 1'b0, 0);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || win8 !== pix(11)) begin
            n_fail++;
            $display("FAIL after_stall_win8: got v%b %h expected v1 %h", out_valid, win8, pix(11));
        end
        @(posedge clk); #1;
        for (int p = 12; p < 16; p++) push_pixel(pix(p), 1'b0, 0);
        drain();
        n_checks++;
        if (n_win - w0 != 4) begin
            n_fail++;
            $display("FAIL backpressure_count: got %0d expected 4", n_win - w0);
        end
    endtask

    task automatic test_toggle_valid();
        int w0;
        do_reset();
        w0 = n_win;
        for (int p = 0; p < 16; p++) push_pixel(pix(p), p == 0, 1);
        drain();
        n_checks++;
        if (n_win - w0 != 4) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d expected 4", n_win - w0);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        do_reset();
        w0 = n_win;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 16; p++) begin
                push_pixel(pix(p), p == 0, 0);
                if (f == 1 && p == 10) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid !== 1'b1 || win8 !== pix(10) || out_row !== 2'd1 || out_col !== 2'd1) begin
                        n_fail++;
                        $display("FAIL frame2_first: got v%b %h r%0d c%0d expected v1 %h r1 c1",
                                 out_valid, win8, out_row, out_col, pix(10));
                    end
                    @(posedge clk); #1;
                end
            end
        end
        drain();
        n_checks++;
        if (n_win - w0 != 8) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d expected 8", n_win - w0);
        end
    endtask

    task automatic test_reset_midframe();
        int w0;
        do_reset();
        for (int p = 0; p < 7; p++) push_pixel(pix(p), p == 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || act_w !== '0 || out_row !== 2'd0 || out_col !== 2'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got v%b w%h r%0d c%0d expected all zero",
                     out_valid, act_w, out_row, out_col);
        end
        @(posedge clk); #1;
        w0 = n_win;
        for (int p = 0; p < 16; p++) begin
            push_pixel(pix(p), 1'b0, 0);
            if (p == 10) begin
                @(negedge clk);
                n_checks++;
                if (out_valid !== 1'b1 || win8 !== pix(10) || win0 !== pix(0) || out_row !== 2'd1 || out_col !== 2'd1) begin
                    n_fail++;
                    $display("FAIL restart_first: got v%b w0 %h w8 %h r%0d c%0d expected v1 %h %h r1 c1",
                             out_valid, win0, win8, out_row, out_col, pix(0), pix(10));
                end
                @(posedge clk); #1;
            end
        end
        drain();
        n_checks++;
        if (n_win - w0 != 4) begin
            n_fail++;
            $display("FAIL restart_count: got %0d expected 4", n_win - w0);
        end
    endtask

    task automatic test_sof_resync();
        int w0;
        do_reset();
        for (int p = 0; p < 5; p++) push_pixel(pix(p + 100), p == 0, 0);
        w0 = n_win;
        for (int p = 0; p < 16; p++) begin
            push_pixel(pix(p), p == 0, 0);
            if (p == 9 || p == 10) begin
                @(negedge clk);
                n_checks++;
                if (out_valid !== (p == 10) || n_win != w0) begin
                    n_fail++;
                    $display("FAIL sof_resync_p%0d: got v%b wins %0d expected v%b wins 0",
                             p, out_valid, n_win - w0, p == 10);
                end
                @(posedge clk); #1;
            end
        end
        drain();
        n_checks++;
        if (n_win - w0 != 4) begin
            n_fail++;
            $display("FAIL sof_resync_count: got %0d expected 4", n_win - w0);
        end
    endtask

    task automatic test_random();
        int w0, idx, cyc;
        logic [DW-1:0] rnd [48];
        bit acc;
        do_reset();
        w0  = n_win;
        idx = 0;
        cyc = 0;
        for (int i = 0; i < 48; i++) rnd[i] = $urandom;
        while (idx < 48 && cyc < 2000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd[idx];
            in_sof    = (idx % 16 == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_sof = 1'b0;
        drain();
        n_checks++;
        if (idx != 48 || n_win - w0 != 12) begin
            n_fail++;
            $display("FAIL random_count: got pixels %0d windows %0d expected 48 and 12", idx, n_win - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_toggle_valid();
        test_back_to_back();
        test_reset_midframe();
        test_sof_resync();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
